// File: rtl/dataflow_model.sv
// dataflow_model: fixed NOR/AND/XOR network on (c,b) giving results a,b,c,y.
// Ports: clk, reset (sync, active-high), in_c/in_b/in_valid in; out_a/b/c/y, out_valid out.
module dataflow_model #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_c,
  input  logic in_b,
  input  logic in_valid,
  output logic out_a,
  output logic out_b,
  output logic out_c,
  output logic out_y,
  output logic out_valid
);

  logic n_a;
  logic n_b;
  logic n_c;
  logic n_y;

  // Gate chain kept in its original form; each net depends on n_a.
  always_comb begin
    n_a = ~(in_c | in_b);
    n_b = ~(~(~in_c & ~n_a) & ~in_c);
    n_c = ~(n_a ^ ~in_b);
    n_y = ~(~in_b & ~n_a);
  end

  if (REG_OUT) begin : g_reg
    logic [4:0] res_d;
    logic [4:0] res_q;

    // Data loads every cycle; in_valid only qualifies it.
    assign res_d = {in_valid, n_a, n_b, n_c, n_y};

    always_ff @(posedge clk) begin
      if (reset) res_q <= '0;
      else       res_q <= res_d;
    end

    assign {out_valid, out_a, out_b, out_c, out_y} = res_q;
  end else begin : g_comb
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ reset;
    assign {out_valid, out_a, out_b, out_c, out_y} =
      {in_valid, n_a, n_b, n_c, n_y};
  end

endmodule

// File: tb/tb_dataflow_model.sv
// tb_dataflow_model: scoreboard bench for dataflow_model.
// Registered and combinational builds checked against a truth-table model.
module tb_dataflow_model;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_c = 1'b0;
  logic in_b = 1'b0;
  logic in_valid = 1'b0;
  logic out_a, out_b, out_c, out_y, out_valid;

  logic cc = 1'b0;
  logic cb = 1'b0;
  logic cv = 1'b0;
  logic ca_o, cb_o, cc_o, cy_o, cv_o;

  int total = 0;
  int bad = 0;
  bit done = 1'b0;

  logic [3:0] tt [4];
  logic [4:0] sb [$];

  always #5 clk = ~clk;

  dataflow_model #(.REG_OUT(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .in_c(in_c), .in_b(in_b), .in_valid(in_valid),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_y(out_y), .out_valid(out_valid)
  );

  dataflow_model #(.REG_OUT(1'b0)) u_comb (
    .clk(clk), .reset(reset),
    .in_c(cc), .in_b(cb), .in_valid(cv),
    .out_a(ca_o), .out_b(cb_o), .out_c(cc_o),
    .out_y(cy_o), .out_valid(cv_o)
  );

  // Reference: (c,b) -> {a,b,c,y}; reset clears everything.
  function automatic logic [4:0] model(
    input logic c, input logic b,
    input logic v, input logic r
  );
    logic [1:0] idx;
    idx = {c, b};
    if (r) return 5'b0;
    return {v, tt[idx]};
  endfunction

  // Expected result of each edge, from the inputs that edge samples.
  always @(posedge clk)
    if (!done) sb.push_back(model(in_c, in_b, in_valid, reset));

  // Monitor: registered outputs present a result every cycle.
  always @(posedge clk) begin
    logic [4:0] exp;
    logic [4:0] act;
    #1;
    if (!done) begin
      act = {out_valid, out_a, out_b, out_c, out_y};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty act=%b", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL reg_out t=%0t act=%b exp=%b", $time, act, exp);
        end
      end
    end
  end

  task automatic step(
    input logic c, input logic b,
    input logic v, input logic r
  );
    @(negedge clk);
    in_c = c;
    in_b = b;
    in_valid = v;
    reset = r;
  endtask

  initial begin
    logic [4:0] act;
    tt[0] = 4'b1011;
    tt[1] = 4'b0111;
    tt[2] = 4'b0100;
    tt[3] = 4'b0111;

    // Reset held for two edges, then release with 00.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);

    // Full sweep.
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);

    // Latency: mid-cycle change must not reach outputs before an edge.
    step(0, 0, 1, 0);
    @(posedge clk);
    #3;
    in_c = 1'b1;
    #1;
    act = {out_valid, out_a, out_b, out_c, out_y};
    total++;
    if (act !== 5'b11011) begin
      bad++;
      $display("FAIL latency act=%b exp=%b", act, 5'b11011);
    end
    step(1, 0, 1, 0);

    // Reset mid-stream discards the in-flight 01 result.
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    step(1, 0, 1, 0);

    // Valid tracking with constant 11.
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom_range(0, 15) == 0));

    step(0, 0, 0, 0);
    @(posedge clk);
    #2;
    done = 1'b1;

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end

    // Combinational build: no edge needed.
    for (int k = 0; k < 8; k++) begin
      logic [1:0] p;
      logic [4:0] exp;
      p = 2'(k % 4);
      cc = p[1];
      cb = p[0];
      cv = 1'($urandom_range(0, 1));
      #1;
      exp = model(cc, cb, cv, 1'b0);
      act = {cv_o, ca_o, cb_o, cc_o, cy_o};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL comb_out cb=%b act=%b exp=%b", p, act, exp);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
